// File: rtl/addsub4_seq_ctrl.sv
// Sequences one add/subtract through an external ripple-carry adder and presents the flagged result.
// Latency: out_valid rises SETTLE_CYC clocks after the accepting edge; throughput 1 op per SETTLE_CYC+2 clocks.
// Backpressure: in_ready is high only in IDLE; the result is held stable while out_ready is low.
module addsub4_seq_ctrl #(
    parameter int WIDTH      = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic [WIDTH-1:0] rca_a,
    output logic [WIDTH-1:0] rca_b,
    output logic             rca_cin,
    input  logic [WIDTH-1:0] rca_s,
    input  logic             rca_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_neg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int          MSB      = WIDTH - 1;
    localparam logic [3:0]  CNT_LAST = 4'(SETTLE_CYC - 1);

    state_t     state;
    logic [3:0] cnt;

    // Requests are taken only while idle; reset leaves the FSM idle, so this reads 1 in reset too.
    assign in_ready = (state == IDLE);

    // Launch operands, wait for the ripple to settle, capture sum and flags, hold until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            rca_a        <= '0;
            rca_b        <= '0;
            rca_cin      <= 1'b0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            out_neg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1, so B is inverted and the +1 rides on carry-in.
                        rca_a   <= in_a;
                        rca_b   <= in_sub ? ~in_b : in_b;
                        rca_cin <= in_sub;
                        cnt     <= 4'd0;
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        out_result   <= rca_s;
                        out_carry    <= rca_cout;
                        // Overflow judged on the conditioned B actually fed to the adder.
                        out_overflow <= (rca_a[MSB] == rca_b[MSB]) && (rca_s[MSB] != rca_a[MSB]);
                        out_zero     <= (rca_s == '0);
                        out_neg      <= rca_s[MSB];
                        out_valid    <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
